// File: rtl/decode_cycle.sv
// ID stage: main/ALU decode, 32x32 register file, immediate extension, ID/EX register.
// Optional macro DECODE_RF_BYPASS_EN enables write-through of ResultW into the ID/EX operands.
module decode_cycle #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [XLEN-1:0]          InstrD,
   input  logic [XLEN-1:0]          PCD,
   input  logic [XLEN-1:0]          PCPlus4D,
   input  logic                     RegWriteW,
   input  logic [$clog2(NREGS)-1:0] RDW,
   input  logic [XLEN-1:0]          ResultW,
   input  logic                     FlushE,
   output logic                     RegWriteE,
   output logic                     MemWriteE,
   output logic                     ResultSrcE,
   output logic                     BranchE,
   output logic                     ALUSrcE,
   output logic [2:0]               ALUControlE,
   output logic [XLEN-1:0]          RD1_E,
   output logic [XLEN-1:0]          RD2_E,
   output logic [XLEN-1:0]          Imm_Ext_E,
   output logic [XLEN-1:0]          PCE,
   output logic [XLEN-1:0]          PCPlus4E,
   output logic [$clog2(NREGS)-1:0] RD_E,
   output logic [$clog2(NREGS)-1:0] RS1_E,
   output logic [$clog2(NREGS)-1:0] RS2_E
);

   localparam int unsigned RegAw = $clog2(NREGS);

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpRType  = 7'b0110011;
   localparam logic [6:0] OpIAlu   = 7'b0010011;
   localparam logic [6:0] OpBranch = 7'b1100011;

   localparam logic [2:0] AluAdd = 3'b000;
   localparam logic [2:0] AluSub = 3'b001;
   localparam logic [2:0] AluAnd = 3'b010;
   localparam logic [2:0] AluOr  = 3'b011;
   localparam logic [2:0] AluSlt = 3'b101;

   typedef struct packed {
      logic             reg_write;
      logic             mem_write;
      logic             result_src;
      logic             branch;
      logic             alu_src;
      logic [2:0]       alu_control;
      logic [XLEN-1:0]  rd1;
      logic [XLEN-1:0]  rd2;
      logic [XLEN-1:0]  imm_ext;
      logic [XLEN-1:0]  pc;
      logic [XLEN-1:0]  pc_plus4;
      logic [RegAw-1:0] rd;
      logic [RegAw-1:0] rs1;
      logic [RegAw-1:0] rs2;
   } idex_t;

   logic [6:0]       opcode;
   logic [2:0]       funct3;
   logic             funct7_b5;
   logic [RegAw-1:0] rs1_idx;
   logic [RegAw-1:0] rs2_idx;
   logic [RegAw-1:0] rd_idx;

   assign opcode    = InstrD[6:0];
   assign funct3    = InstrD[14:12];
   assign funct7_b5 = InstrD[30];
   assign rs1_idx   = InstrD[19:15];
   assign rs2_idx   = InstrD[24:20];
   assign rd_idx    = InstrD[11:7];

   // Main decoder
   logic       reg_write;
   logic       mem_write;
   logic       result_src;
   logic       branch;
   logic       alu_src;
   logic [1:0] imm_src;
   logic [1:0] alu_op;

   always_comb begin
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      result_src = 1'b0;
      branch     = 1'b0;
      alu_src    = 1'b0;
      imm_src    = 2'b00;
      alu_op     = 2'b00;
      case (opcode)
         OpLoad: begin
            reg_write  = 1'b1;
            result_src = 1'b1;
            alu_src    = 1'b1;
         end
         OpStore: begin
            mem_write = 1'b1;
            alu_src   = 1'b1;
            imm_src   = 2'b01;
         end
         OpRType: begin
            reg_write = 1'b1;
            alu_op    = 2'b10;
         end
         OpIAlu: begin
            reg_write = 1'b1;
            alu_src   = 1'b1;
            alu_op    = 2'b10;
         end
         OpBranch: begin
            branch  = 1'b1;
            imm_src = 2'b10;
            alu_op  = 2'b01;
         end
         default: ;
      endcase
   end

   // ALU decoder; sub only for R-type with funct7[5] so addi with imm[10]=1 stays add
   logic [2:0] alu_control;

   always_comb begin
      alu_control = AluAdd;
      case (alu_op)
         2'b00: alu_control = AluAdd;
         2'b01: alu_control = AluSub;
         2'b10: begin
            case (funct3)
               3'b000:  alu_control = (opcode[5] & funct7_b5) ? AluSub : AluAdd;
               3'b010:  alu_control = AluSlt;
               3'b110:  alu_control = AluOr;
               3'b111:  alu_control = AluAnd;
               default: alu_control = AluAdd;
            endcase
         end
         default: alu_control = AluAdd;
      endcase
   end

   logic [XLEN-1:0] imm_ext;

   always_comb begin
      imm_ext = '0;
      case (imm_src)
         2'b00:   imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
         2'b01:   imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
         2'b10:   imm_ext = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25],
                             InstrD[11:8], 1'b0};
         default: imm_ext = '0;
      endcase
   end

   // Register file: x0 is never written and reads as zero
   logic [XLEN-1:0] rf_q [NREGS];
   logic [XLEN-1:0] rf_d [NREGS];
   logic            rf_we;

   assign rf_we = RegWriteW && (RDW != '0);

   always_comb begin
      rf_d = rf_q;
      if (rf_we) begin
         rf_d[RDW] = ResultW;
      end
   end

   logic [XLEN-1:0] rd1;
   logic [XLEN-1:0] rd2;

   always_comb begin
      rd1 = (rs1_idx == '0) ? '0 : rf_q[rs1_idx];
      rd2 = (rs2_idx == '0) ? '0 : rf_q[rs2_idx];
`ifdef DECODE_RF_BYPASS_EN
      if (rf_we && (RDW == rs1_idx)) rd1 = ResultW;
      if (rf_we && (RDW == rs2_idx)) rd2 = ResultW;
`endif
   end

   // ID/EX pipeline register
   idex_t idex_d;
   idex_t idex_q;

   always_comb begin
      idex_d = '0;
      if (!FlushE) begin
         idex_d.reg_write   = reg_write;
         idex_d.mem_write   = mem_write;
         idex_d.result_src  = result_src;
         idex_d.branch      = branch;
         idex_d.alu_src     = alu_src;
         idex_d.alu_control = alu_control;
         idex_d.rd1         = rd1;
         idex_d.rd2         = rd2;
         idex_d.imm_ext     = imm_ext;
         idex_d.pc          = PCD;
         idex_d.pc_plus4    = PCPlus4D;
         idex_d.rd          = rd_idx;
         idex_d.rs1         = rs1_idx;
         idex_d.rs2         = rs2_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idex_q <= '0;
         for (int i = 0; i < int'(NREGS); i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         idex_q <= idex_d;
         rf_q   <= rf_d;
      end
   end

   assign RegWriteE   = idex_q.reg_write;
   assign MemWriteE   = idex_q.mem_write;
   assign ResultSrcE  = idex_q.result_src;
   assign BranchE     = idex_q.branch;
   assign ALUSrcE     = idex_q.alu_src;
   assign ALUControlE = idex_q.alu_control;
   assign RD1_E       = idex_q.rd1;
   assign RD2_E       = idex_q.rd2;
   assign Imm_Ext_E   = idex_q.imm_ext;
   assign PCE         = idex_q.pc;
   assign PCPlus4E    = idex_q.pc_plus4;
   assign RD_E        = idex_q.rd;
   assign RS1_E       = idex_q.rs1;
   assign RS2_E       = idex_q.rs2;

endmodule

// File: tb/tb_decode_cycle.sv
// Directed table-driven bench for decode_cycle; expectations follow DECODE_RF_BYPASS_EN.
module tb_decode_cycle;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
   logic        RegWriteW, FlushE;
   logic [4:0]  RDW;
   logic        RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
   logic [4:0]  RD_E, RS1_E, RS2_E;

   int checks = 0;
   int errors = 0;

`ifdef DECODE_RF_BYPASS_EN
   localparam bit Byp = 1'b1;
`else
   localparam bit Byp = 1'b0;
`endif

   always #5 clk = ~clk;

   decode_cycle dut (
      .clk        (clk),
      .rst        (rst),
      .InstrD     (InstrD),
      .PCD        (PCD),
      .PCPlus4D   (PCPlus4D),
      .RegWriteW  (RegWriteW),
      .RDW        (RDW),
      .ResultW    (ResultW),
      .FlushE     (FlushE),
      .RegWriteE  (RegWriteE),
      .MemWriteE  (MemWriteE),
      .ResultSrcE (ResultSrcE),
      .BranchE    (BranchE),
      .ALUSrcE    (ALUSrcE),
      .ALUControlE(ALUControlE),
      .RD1_E      (RD1_E),
      .RD2_E      (RD2_E),
      .Imm_Ext_E  (Imm_Ext_E),
      .PCE        (PCE),
      .PCPlus4E   (PCPlus4E),
      .RD_E       (RD_E),
      .RS1_E      (RS1_E),
      .RS2_E      (RS2_E)
   );

   typedef struct {
      logic [31:0] instr;
      logic        flush;
      logic        we;
      logic [4:0]  rdw;
      logic [31:0] wdata;
      logic [4:0]  ctl;      // {regwrite, memwrite, resultsrc, branch, alusrc}
      logic [2:0]  aluctl;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic        imm_care;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
   } vec_t;

   function automatic vec_t mk(input logic [31:0] instr, input logic flush, input logic we,
                               input logic [4:0] rdw, input logic [31:0] wdata,
                               input logic [4:0] ctl, input logic [2:0] aluctl,
                               input logic [31:0] rd1, input logic [31:0] rd2,
                               input logic [31:0] imm, input logic imm_care,
                               input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2);
      vec_t v;
      v.instr = instr; v.flush = flush; v.we = we; v.rdw = rdw; v.wdata = wdata;
      v.ctl = ctl; v.aluctl = aluctl; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm;
      v.imm_care = imm_care; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v, input logic [31:0] pc);
      InstrD    = v.instr;
      FlushE    = v.flush;
      RegWriteW = v.we;
      RDW       = v.rdw;
      ResultW   = v.wdata;
      PCD       = pc;
      PCPlus4D  = pc + 32'd4;
   endtask

   task automatic check_vec(input string tag, input vec_t v, input logic [31:0] pc,
                            input logic [31:0] pc4);
      check({tag, " ctl"}, {27'd0, RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE},
            {27'd0, v.ctl});
      check({tag, " aluctl"}, {29'd0, ALUControlE}, {29'd0, v.aluctl});
      check({tag, " rd1"}, RD1_E, v.rd1);
      check({tag, " rd2"}, RD2_E, v.rd2);
      if (v.imm_care) check({tag, " imm"}, Imm_Ext_E, v.imm);
      check({tag, " pc"}, PCE, pc);
      check({tag, " pc4"}, PCPlus4E, pc4);
      check({tag, " regs"}, {17'd0, RD_E, RS1_E, RS2_E}, {17'd0, v.rd, v.rs1, v.rs2});
   endtask

   vec_t tbl[18];
   vec_t zero_v;
   vec_t wr_v;

   initial begin
      logic [31:0] byp5;
      byp5 = Byp ? 32'h0000_1234 : 32'h0000_00AA;
      zero_v = mk(32'h0, 0, 0, 5'd0, 32'h0, 5'b00000, 3'b000, 32'h0, 32'h0, 32'h0, 1, 5'd0,
                  5'd0, 5'd0);
      //            instr         fl we rdw   wdata          ctl       alu     rd1            rd2            imm            ic rd  rs1 rs2
      tbl[0]  = mk(32'h0000_0000, 0, 1, 5'd5, 32'h0000_00AA, 5'b00000, 3'b000, 32'h0,         32'h0,         32'h0,         1, 0,  0,  0);
      tbl[1]  = mk(32'h0052_8313, 0, 0, 5'd0, 32'h0,         5'b10001, 3'b000, 32'hAA,        32'hAA,        32'h5,         1, 6,  5,  5);
      tbl[2]  = mk(32'h4062_83B3, 0, 0, 5'd0, 32'h0,         5'b10000, 3'b001, 32'hAA,        32'h0,         32'h0,         0, 7,  5,  6);
      tbl[3]  = mk(32'hFE52_8EE3, 0, 0, 5'd0, 32'h0,         5'b00010, 3'b001, 32'hAA,        32'hAA,        32'hFFFF_FFFC, 1, 29, 5,  5);
      tbl[4]  = mk(32'hFE52_8EE3, 1, 1, 5'd6, 32'h0000_0066, 5'b00000, 3'b000, 32'h0,         32'h0,         32'h0,         1, 0,  0,  0);
      tbl[5]  = mk(32'h4062_83B3, 0, 0, 5'd0, 32'h0,         5'b10000, 3'b001, 32'hAA,        32'h66,        32'h0,         0, 7,  5,  6);
      tbl[6]  = mk(32'h0082_A403, 0, 0, 5'd0, 32'h0,         5'b10101, 3'b000, 32'hAA,        32'h0,         32'h8,         1, 8,  5,  8);
      tbl[7]  = mk(32'hFE62_AC23, 0, 0, 5'd0, 32'h0,         5'b01001, 3'b000, 32'hAA,        32'h66,        32'hFFFF_FFF8, 1, 24, 5,  6);
      tbl[8]  = mk(32'h0062_A4B3, 0, 0, 5'd0, 32'h0,         5'b10000, 3'b101, 32'hAA,        32'h66,        32'h0,         0, 9,  5,  6);
      tbl[9]  = mk(32'h0062_E533, 0, 0, 5'd0, 32'h0,         5'b10000, 3'b011, 32'hAA,        32'h66,        32'h0,         0, 10, 5,  6);
      tbl[10] = mk(32'h0062_F5B3, 0, 0, 5'd0, 32'h0,         5'b10000, 3'b010, 32'hAA,        32'h66,        32'h0,         0, 11, 5,  6);
      tbl[11] = mk(32'hFFF2_F613, 0, 0, 5'd0, 32'h0,         5'b10001, 3'b010, 32'hAA,        32'h0,         32'hFFFF_FFFF, 1, 12, 5,  31);
      tbl[12] = mk(32'h4002_8693, 0, 0, 5'd0, 32'h0,         5'b10001, 3'b000, 32'hAA,        32'h0,         32'h400,       1, 13, 5,  0);
      tbl[13] = mk(32'h0062_A4B7, 0, 0, 5'd0, 32'h0,         5'b00000, 3'b000, 32'hAA,        32'h66,        32'h0,         0, 9,  5,  6);
      tbl[14] = mk(32'h0000_0093, 0, 1, 5'd0, 32'hDEAD_BEEF, 5'b10001, 3'b000, 32'h0,         32'h0,         32'h0,         1, 1,  0,  0);
      tbl[15] = mk(32'h0000_0093, 0, 0, 5'd0, 32'h0,         5'b10001, 3'b000, 32'h0,         32'h0,         32'h0,         1, 1,  0,  0);
      tbl[16] = mk(32'h0052_8313, 0, 1, 5'd5, 32'h0000_1234, 5'b10001, 3'b000, byp5,          byp5,          32'h5,         1, 6,  5,  5);
      tbl[17] = mk(32'h0052_8313, 0, 0, 5'd0, 32'h0,         5'b10001, 3'b000, 32'h1234,      32'h1234,      32'h5,         1, 6,  5,  5);

      // Dirty some registers, then confirm reset clears them and overrides a write
      rst = 1'b1;
      drive(zero_v, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      wr_v = zero_v; wr_v.we = 1'b1; wr_v.rdw = 5'd3; wr_v.wdata = 32'h33;
      drive(wr_v, 32'h0);
      @(posedge clk); #1;
      wr_v = zero_v; wr_v.instr = 32'h3 << 15; wr_v.we = 1'b1; wr_v.rdw = 5'd31;
      wr_v.wdata = 32'hFF;
      drive(wr_v, 32'h0);
      @(posedge clk); #1;
      check("prereset x3", RD1_E, 32'h33);

      rst = 1'b1;
      wr_v = tbl[1]; wr_v.we = 1'b1; wr_v.rdw = 5'd7; wr_v.wdata = 32'h77; wr_v.flush = 1'b0;
      for (int c = 0; c < 2; c++) begin
         drive(wr_v, 32'h40);
         @(posedge clk); #1;
         check_vec($sformatf("reset%0d", c), zero_v, 32'h0, 32'h0);
      end
      rst = 1'b0;
      drive(zero_v, 32'h0);
      @(posedge clk); #1;
      check_vec("postreset", zero_v, 32'h0, 32'h4);

      for (int r = 1; r < 32; r++) begin
         wr_v = zero_v;
         wr_v.instr = (32'(r) << 20) | (32'(r) << 15);
         drive(wr_v, 32'h0);
         @(posedge clk); #1;
         check($sformatf("clr x%0d rs1", r), RD1_E, 32'h0);
         check($sformatf("clr x%0d rs2", r), RD2_E, 32'h0);
      end

      for (int i = 0; i < 18; i++) begin
         logic [31:0] pc;
         pc = 32'h100 + 32'(i) * 32'd4;
         drive(tbl[i], pc);
         @(posedge clk); #1;
         if (tbl[i].flush) check_vec($sformatf("v%0d", i), tbl[i], 32'h0, 32'h0);
         else check_vec($sformatf("v%0d", i), tbl[i], pc, pc + 32'd4);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
